// File: rtl/ping_banner_pkg.sv
// Shared constants and blink state encoding for the PING banner renderer.
package ping_banner_pkg;

  localparam int BANNER_W = 128;
  localparam int BANNER_H = 32;
  localparam int ROW_AW   = 5;
  localparam int COL_AW   = 7;
  localparam int RGB_W    = 12;

  typedef enum logic [1:0] {
    HIDDEN    = 2'd0,
    SHOWN     = 2'd1,
    BLINK_ON  = 2'd2,
    BLINK_OFF = 2'd3
  } blink_state_e;

endpackage

// File: rtl/banner_blink_ctrl.sv
// Frame-synchronous show/blink controller; enable and blink_en only take
// effect on frame_tick so the banner never tears mid-frame.
module banner_blink_ctrl
  import ping_banner_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic reset_n,
  input  logic frame_tick,
  input  logic enable,
  input  logic blink_en,
  output logic visible
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  blink_state_e     state_r;
  blink_state_e     state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // State and frame counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= HIDDEN;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state and counter update, evaluated only on frame boundaries
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (frame_tick) begin
      if (!enable) begin
        state_next_s = HIDDEN;
        cnt_next_s   = {CNT_W{1'b0}};
      end else if (!blink_en) begin
        state_next_s = SHOWN;
        cnt_next_s   = {CNT_W{1'b0}};
      end else begin
        case (state_r)
          BLINK_ON, BLINK_OFF: begin
            if (cnt_r == CNT_LAST) begin
              state_next_s = (state_r == BLINK_ON) ? BLINK_OFF : BLINK_ON;
              cnt_next_s   = {CNT_W{1'b0}};
            end else begin
              cnt_next_s   = cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_next_s = BLINK_ON;
            cnt_next_s   = {CNT_W{1'b0}};
          end
        endcase
      end
    end else begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
    end
  end

  // Visibility decode
  always_comb begin
    visible = (state_r == SHOWN) || (state_r == BLINK_ON);
  end

endmodule

// File: rtl/ping_banner_renderer.sv
// Reader side of the PING banner ROM: coordinate mapping, 2-stage pixel
// pipeline and sync delay so the banner pixel stays aligned with the syncs.
module ping_banner_renderer
  import ping_banner_pkg::*;
#(
  parameter int               BANNER_X     = 256,
  parameter int               BANNER_Y     = 224,
  parameter int               SCALE_LOG2   = 0,
  parameter int               BLINK_FRAMES = 30,
  parameter logic [RGB_W-1:0] FG_COLOR     = 12'hFFF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [9:0]          pixel_x,
  input  logic [9:0]          pixel_y,
  input  logic                video_on,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic                blink_en,
  output logic [ROW_AW-1:0]   drom_addr_num,
  input  logic [BANNER_W-1:0] drom_data_num,
  output logic                pixel_on,
  output logic [RGB_W-1:0]    rgb,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                video_on_out
);

  localparam logic signed [10:0] BOX_W = 11'(BANNER_W << SCALE_LOG2);
  localparam logic signed [10:0] BOX_H = 11'(BANNER_H << SCALE_LOG2);

  logic signed [10:0]  dx_s;
  logic signed [10:0]  dy_s;
  logic                in_box_s;
  logic                visible_s;
  logic                pixel_on_next_s;
  logic [BANNER_W-1:0] row_r;
  logic [COL_AW-1:0]   col_r;
  logic                in_r;
  logic                hsync_d1_r;
  logic                vsync_d1_r;
  logic                video_on_d1_r;

  banner_blink_ctrl #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink (
    .clk       (clk),
    .reset_n   (reset_n),
    .frame_tick(frame_tick),
    .enable    (enable),
    .blink_en  (blink_en),
    .visible   (visible_s)
  );

  // Signed offsets keep pixels left of / above the banner negative, never wrapping
  assign dx_s = $signed({1'b0, pixel_x}) - $signed(11'(BANNER_X));
  assign dy_s = $signed({1'b0, pixel_y}) - $signed(11'(BANNER_Y));
  assign in_box_s = (dx_s >= 11'sd0) && (dx_s < BOX_W) &&
                    (dy_s >= 11'sd0) && (dy_s < BOX_H);
  assign drom_addr_num   = dy_s[SCALE_LOG2 +: ROW_AW];
  assign pixel_on_next_s = in_r & row_r[col_r];

  // Stage 1: capture ROM row, column index and gating alongside the syncs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      row_r         <= {BANNER_W{1'b0}};
      col_r         <= {COL_AW{1'b0}};
      in_r          <= 1'b0;
      hsync_d1_r    <= 1'b0;
      vsync_d1_r    <= 1'b0;
      video_on_d1_r <= 1'b0;
    end else begin
      row_r         <= drom_data_num;
      col_r         <= dx_s[SCALE_LOG2 +: COL_AW];
      in_r          <= in_box_s & video_on & visible_s;
      hsync_d1_r    <= hsync_in;
      vsync_d1_r    <= vsync_in;
      video_on_d1_r <= video_on;
    end
  end

  // Stage 2: column select, colour and second sync delay
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_on     <= 1'b0;
      rgb          <= {RGB_W{1'b0}};
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      video_on_out <= 1'b0;
    end else begin
      pixel_on     <= pixel_on_next_s;
      rgb          <= pixel_on_next_s ? FG_COLOR : {RGB_W{1'b0}};
      hsync_out    <= hsync_d1_r;
      vsync_out    <= vsync_d1_r;
      video_on_out <= video_on_d1_r;
    end
  end

endmodule

// File: tb/tb_ping_banner_renderer.sv
// Directed bench for ping_banner_renderer: one unscaled and one 2x-scaled
// instance share stimulus, each paired with a small behavioural banner ROM.
module tb_ping_banner_renderer;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [9:0]   pixel_x, pixel_y;
  logic         video_on, hsync_in, vsync_in, frame_tick, enable, blink_en;
  logic [4:0]   addr0, addr1;
  logic [127:0] data0, data1;
  logic         pon0, pon1, hs0, hs1, vs0, vs1, vo0, vo1;
  logic [11:0]  rgb0, rgb1;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  // Row 0: bits 1,127.  Row r>0: bits 0,1,127 plus r shifted up to bit 8.
  function automatic logic [127:0] rom_row(input logic [4:0] a);
    logic [127:0] r;
    r = 128'h8000_0000_0000_0000_0000_0000_0000_0002;
    if (a != 5'd0) r = r | 128'd1 | ({123'd0, a} << 8);
    else           r = r;
    return r;
  endfunction

  assign data0 = rom_row(addr0);
  assign data1 = rom_row(addr1);

  ping_banner_renderer #(.SCALE_LOG2(0), .BLINK_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_tick(frame_tick), .enable(enable), .blink_en(blink_en),
    .drom_addr_num(addr0), .drom_data_num(data0), .pixel_on(pon0), .rgb(rgb0),
    .hsync_out(hs0), .vsync_out(vs0), .video_on_out(vo0));

  ping_banner_renderer #(.SCALE_LOG2(1), .BLINK_FRAMES(2)) dut_s (
    .clk(clk), .reset_n(reset_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .frame_tick(frame_tick), .enable(enable), .blink_en(blink_en),
    .drom_addr_num(addr1), .drom_data_num(data1), .pixel_on(pon1), .rgb(rgb1),
    .hsync_out(hs1), .vsync_out(vs1), .video_on_out(vo1));

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
    #1;
  endtask

  task automatic settle();
    step();
    step();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b1;
    hsync_in = 1'b0; vsync_in = 1'b0; frame_tick = 1'b0;
    enable = 1'b0; blink_en = 1'b0;
    repeat (3) step();
    check_eq("reset_pixel_on", pon0, 1'b0);
    check_eq("reset_rgb", rgb0, 12'h000);
    reset_n = 1'b1;

    // Enabled but not yet sampled on a frame tick
    enable = 1'b1;
    pix(257, 224); settle();
    check_eq("hidden_before_tick", pon0, 1'b0);
    tick();

    pix(256, 224); check_eq("addr_256_224", addr0, 5'd0); settle();
    check_eq("pon_256_224", pon0, 1'b0);
    check_eq("rgb_256_224", rgb0, 12'h000);
    pix(257, 224); check_eq("addr_257_224", addr0, 5'd0); settle();
    check_eq("pon_257_224", pon0, 1'b1);
    check_eq("rgb_257_224", rgb0, 12'hFFF);
    pix(256, 225); check_eq("addr_256_225", addr0, 5'd1); settle();
    check_eq("pon_256_225", pon0, 1'b1);
    check_eq("rgb_256_225", rgb0, 12'hFFF);
    pix(264, 225); settle(); check_eq("pon_col8_row1", pon0, 1'b1);
    pix(260, 225); settle(); check_eq("pon_col4_row1", pon0, 1'b0);

    // Edges
    pix(255, 225); settle(); check_eq("pon_left_of_box", pon0, 1'b0);
    pix(384, 225); settle(); check_eq("pon_right_of_box", pon0, 1'b0);
    pix(257, 256); settle(); check_eq("pon_below_box", pon0, 1'b0);
    pix(257, 223); settle(); check_eq("pon_above_box", pon0, 1'b0);
    pix(256, 255); check_eq("addr_last_row", addr0, 5'd31); settle();
    check_eq("pon_last_row", pon0, 1'b1);
    pix(383, 224); settle(); check_eq("pon_col127", pon0, 1'b1);
    video_on = 1'b0;
    pix(257, 224); settle(); check_eq("pon_video_off", pon0, 1'b0);
    video_on = 1'b1;

    // Sync alignment
    hsync_in = 1'b1; vsync_in = 1'b0;
    step(); check_eq("hsync_lag1", hs0, 1'b0);
    step(); check_eq("hsync_lag2", hs0, 1'b1);
    hsync_in = 1'b0; vsync_in = 1'b1; video_on = 1'b0;
    step();
    check_eq("hsync_fall_lag1", hs0, 1'b1);
    check_eq("vsync_lag1", vs0, 1'b0);
    check_eq("video_on_lag1", vo0, 1'b1);
    step();
    check_eq("hsync_fall_lag2", hs0, 1'b0);
    check_eq("vsync_lag2", vs0, 1'b1);
    check_eq("video_on_lag2", vo0, 1'b0);
    vsync_in = 1'b0; video_on = 1'b1;

    // Scaled instance (2x)
    pix(258, 226); check_eq("s_addr_258_226", addr1, 5'd1); settle();
    check_eq("s_pon_258_226", pon1, 1'b1);
    check_eq("s_rgb_258_226", rgb1, 12'hFFF);
    pix(260, 226); settle(); check_eq("s_pon_col2", pon1, 1'b0);
    pix(511, 287); check_eq("s_addr_511_287", addr1, 5'd31); settle();
    check_eq("s_pon_511_287", pon1, 1'b1);
    pix(512, 226); settle(); check_eq("s_pon_512_out", pon1, 1'b0);

    // Frame-synchronous disable
    pix(257, 224);
    enable = 1'b0; settle();
    check_eq("disable_mid_frame", pon0, 1'b1);
    tick(); settle();
    check_eq("disable_after_tick", pon0, 1'b0);
    pix(256, 225); settle();
    check_eq("disable_whole_frame", pon0, 1'b0);

    // Blink, two frames per half-period
    pix(257, 224);
    enable = 1'b1; blink_en = 1'b1;
    tick(); settle(); check_eq("blink_frame1", pon0, 1'b1);
    tick(); settle(); check_eq("blink_frame2", pon0, 1'b1);
    tick(); settle(); check_eq("blink_frame3", pon0, 1'b0);
    tick(); settle(); check_eq("blink_frame4", pon0, 1'b0);
    tick(); settle(); check_eq("blink_frame5", pon0, 1'b1);
    tick(); settle(); check_eq("blink_frame6", pon0, 1'b1);
    tick(); settle(); check_eq("blink_frame7", pon0, 1'b0);
    blink_en = 1'b0; settle();
    check_eq("blink_off_hold", pon0, 1'b0);
    tick(); settle(); check_eq("blink_off_to_shown", pon0, 1'b1);
    tick(); settle(); check_eq("shown_steady", pon0, 1'b1);

    // Asynchronous reset mid-line
    hsync_in = 1'b1; settle();
    check_eq("pre_reset_hsync", hs0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("async_rst_pixel_on", pon0, 1'b0);
    check_eq("async_rst_rgb", rgb0, 12'h000);
    check_eq("async_rst_hsync", hs0, 1'b0);
    check_eq("async_rst_s_pixel_on", pon1, 1'b0);
    step();
    reset_n = 1'b1; hsync_in = 1'b0;
    settle();
    check_eq("post_reset_hidden", pon0, 1'b0);
    tick(); settle();
    check_eq("post_reset_shown", pon0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ping_banner_renderer.md
Name: ping_banner_renderer

Overview:
- Reader side of the 32x128 "PING" banner bitmap ROM.
- The ROM is a combinational row lookup: a 5-bit row address returns a 128-bit row, where bit index 0 is the leftmost pixel.
- This block sits between the VGA sync generator and the RGB mux. From the current pixel coordinates it drives the ROM row address, registers the returned row, selects the column bit and emits a pipelined pixel/colour with sync signals aligned to it.
- A frame-synchronous show/blink controller gates visibility, for example a blinking title before serve.

Parameters:
- BANNER_X, 256: left edge of the banner in screen pixels.
- BANNER_Y, 224: top edge of the banner in screen pixels.
- SCALE_LOG2, 0: each ROM pixel is replicated 2^SCALE_LOG2 times in x and y. Legal values are 0..2.
- BLINK_FRAMES, 30: number of frames per blink half-period. Must be at least 1.
- FG_COLOR, 12'hFFF: RGB444 colour of banner pixels.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- pixel_x  in  10  current column from the sync generator
- pixel_y  in  10  current row from the sync generator
- video_on  in  1  active display area
- hsync_in  in  1  horizontal sync from the sync generator
- vsync_in  in  1  vertical sync from the sync generator
- frame_tick  in  1  one-cycle pulse at the start of each frame
- enable  in  1  request to show the banner
- blink_en  in  1  request to blink instead of steady display
- drom_addr_num  out  5  row address to the bitmap ROM
- drom_data_num  in  128  row data from the ROM, index [0:127], bit 0 is leftmost
- pixel_on  out  1  banner pixel lit
- rgb  out  12  FG_COLOR when pixel_on, else 0
- hsync_out  out  1  hsync_in delayed 2 cycles
- vsync_out  out  1  vsync_in delayed 2 cycles
- video_on_out  out  1  video_on delayed 2 cycles

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - pixel_on, rgb, hsync_out, vsync_out, video_on_out and all pipeline registers are 0.
  - The FSM is in HIDDEN and the frame counter is 0.
  - Asserting reset mid-frame forces the outputs to 0 immediately.
- Stage 0 (combinational):
  - dx = pixel_x - BANNER_X and dy = pixel_y - BANNER_Y, computed at 11 bits signed.
  - in_box = (dx >= 0) && (dx < 128<<SCALE_LOG2) && (dy >= 0) && (dy < 32<<SCALE_LOG2).
  - drom_addr_num = (dy >> SCALE_LOG2)[4:0], driven every cycle. Its value is don't-care when not in_box.
- Stage 1 (registered):
  - row_q <= drom_data_num
  - col_q <= (dx >> SCALE_LOG2)[6:0]
  - in_q <= in_box & video_on & visible
  - The three sync signals are delayed alongside.
- Stage 2 (registered):
  - pixel_on <= in_q & row_q[col_q]
  - rgb <= pixel_on_next ? FG_COLOR : 0
  - The sync signals are delayed a second time.
- Latency is exactly 2 clocks from pixel_x/pixel_y/video_on to pixel_on/rgb. The sync outputs have the same latency, so alignment is preserved.
- Blink FSM states: HIDDEN, SHOWN, BLINK_ON, BLINK_OFF.
  - visible = (state == SHOWN) || (state == BLINK_ON).
  - enable and blink_en are sampled only on frame_tick, so there is no mid-frame tearing.
- Transitions on frame_tick:
  - !enable -> HIDDEN; counter cleared.
  - enable & !blink_en -> SHOWN; counter cleared.
  - enable & blink_en from HIDDEN or SHOWN -> BLINK_ON; counter cleared.
  - In BLINK_ON or BLINK_OFF: the counter increments. When it reaches BLINK_FRAMES-1, the state toggles and the counter clears.
- With no frame_tick, the state and counter hold.
- Boundaries:
  - Pixels left of or above the banner give negative dx/dy and are out of box; there is no wrap.
  - With SCALE_LOG2=0, x = BANNER_X+127 is column 127 and x = BANNER_X+128 is out of box.
  - video_on=0 forces pixel_on=0.
  - Deasserting blink_en while in BLINK_OFF moves to SHOWN at the next frame_tick.

Decomposition:
- Shared package ping_banner_pkg holds:
  - BANNER_W=128, BANNER_H=32, ROW_AW=5, COL_AW=7, RGB_W=12.
  - The blink state encoding.
- Sub-module banner_blink_ctrl holds the FSM and frame counter. Its inputs are clk, reset_n, frame_tick, enable, blink_en; its output is visible.
- The top-level block contains the coordinate logic and the 2-stage pipeline, and is paired with the existing ROM in the testbench.

Test Plan:
- Reset: drive reset_n low mid-line with enable=1 -> all outputs 0 within the same cycle. After release, nothing is shown until enable is sampled on a frame_tick.
- Pixel lookup: enable=1, frame_tick, then pixels (256,224), (257,224), (256,225) -> drom_addr_num 0/0/1 and pixel_on 0/1/1 two cycles later, with rgb 000/FFF/FFF.
- Edges: (255,224), (384,224), (256,256) -> pixel_on 0. (256,255) -> drom_addr_num=31 and pixel_on=1. (383,224) -> pixel_on=1 from bit 127.
- Blink: BLINK_FRAMES=2, enable=1, blink_en=1 -> visible for frames 1-2, hidden for 3-4, visible for 5-6. Clearing blink_en during a hidden frame -> SHOWN from the next frame.
- Frame sync: toggle enable to 0 mid-frame -> pixel_on unchanged until frame_tick, then 0 for the entire next frame.
- Scaling: SCALE_LOG2=1, pixel (258,226) -> drom_addr_num=1, col 1, pixel_on=1. Pixel (511,287) in box, (512,224) out of box. Sync outputs lag their inputs by exactly 2 cycles.
